// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per requester
// (pipeline MEM stage, loader/debug port).
interface dmem_arbiter_if #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_LEN  = 5
);
   logic                 req;
   logic                 we;
   logic [ADDR_LEN-1:0]  addr;
   logic [WORD_SIZE-1:0] wdata;
   logic                 gnt;
   logic                 rvalid;
   logic [WORD_SIZE-1:0] rdata;
   logic                 err;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: fixed priority for P,
// bounded starvation for L, range checking, and one-cycle response routing.
module dmem_arbiter #(
   parameter int WORD_SIZE  = 32,
   parameter int ADDR_LEN   = 5,
   parameter int MEM_SIZE   = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   dmem_arbiter_if.slave        p,
   dmem_arbiter_if.slave        l,
   output logic                 m_en,
   output logic                 m_we,
   output logic [ADDR_LEN-1:0]  m_addr,
   output logic [WORD_SIZE-1:0] m_wdata,
   input  logic [WORD_SIZE-1:0] m_rdata
);

   typedef enum logic [1:0] {K_RD, K_WR, K_ERR} kind_t;

   localparam logic [3:0]        LIM = 4'(STARVE_LIM);
   localparam logic [ADDR_LEN:0] MSZ = (ADDR_LEN+1)'(MEM_SIZE);

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= LIM) ? LIM : v + 4'd1;
   endfunction

   function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
      if (MEM_SIZE >= (1 << ADDR_LEN)) return 1'b1;
      return ({1'b0, a} < MSZ);
   endfunction

   logic [3:0]           starve_cnt;
   logic                 l_force, p_win, l_win, any_win, sel_inr;
   logic                 sel_we;
   logic [ADDR_LEN-1:0]  sel_addr;
   logic [WORD_SIZE-1:0] sel_wdata;

   logic                 resp_vld_p1;
   logic                 resp_owner_p1;
   kind_t                resp_kind_p1;
   logic                 resp_on, p_rv, l_rv;
   logic [WORD_SIZE-1:0] resp_data;

   // stage p0: arbitration and memory command
   always_comb begin
      l_force   = l.req && (starve_cnt == LIM);
      p_win     = rstn && p.req && !l_force;
      l_win     = rstn && l.req && !p_win;
      any_win   = p_win || l_win;
      sel_we    = l_win ? l.we    : p.we;
      sel_addr  = l_win ? l.addr  : p.addr;
      sel_wdata = l_win ? l.wdata : p.wdata;
      sel_inr   = in_range(sel_addr);
      m_en      = any_win && sel_inr;
      m_we      = m_en && sel_we;
      m_addr    = m_en ? sel_addr  : '0;
      m_wdata   = m_en ? sel_wdata : '0;
   end

   assign p.gnt = p_win;
   assign l.gnt = l_win;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         starve_cnt    <= '0;
         resp_vld_p1   <= 1'b0;
         resp_owner_p1 <= 1'b0;
         resp_kind_p1  <= K_RD;
      end else begin
         starve_cnt    <= (l.req && !l_win) ? sat_inc(starve_cnt) : 4'd0;
         resp_vld_p1   <= any_win;
         resp_owner_p1 <= l_win;
         resp_kind_p1  <= !sel_inr ? K_ERR : (sel_we ? K_WR : K_RD);
      end
   end

   // stage p1: response steering; a pending response is hidden while in reset
   always_comb begin
      resp_on   = rstn && resp_vld_p1;
      p_rv      = resp_on && !resp_owner_p1;
      l_rv      = resp_on &&  resp_owner_p1;
      resp_data = (resp_kind_p1 == K_RD) ? m_rdata : '0;
   end

   assign p.rvalid = p_rv;
   assign p.rdata  = p_rv ? resp_data : '0;
   assign p.err    = p_rv && (resp_kind_p1 == K_ERR);
   assign l.rvalid = l_rv;
   assign l.rdata  = l_rv ? resp_data : '0;
   assign l.err    = l_rv && (resp_kind_p1 == K_ERR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, reference memory and
// a response scoreboard filled at acceptance and drained one cycle later.
module tb_dmem_arbiter;
   localparam int WS  = 32;
   localparam int AL  = 5;
   localparam int MS  = 20;
   localparam int LIM = 4;

   typedef struct {
      logic          owner;
      logic [WS-1:0] rdata;
      logic          err;
   } resp_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          m_en, m_we;
   logic [AL-1:0] m_addr;
   logic [WS-1:0] m_wdata, m_rdata;

   logic [WS-1:0] mem     [32];
   logic [WS-1:0] ref_mem [32];
   resp_t         sbq [$];
   int            nchk = 0, nerr = 0;
   int            ms = 0;
   logic          gl_last;
   int            l_accepts;

   dmem_arbiter_if #(.WORD_SIZE(WS), .ADDR_LEN(AL)) pif ();
   dmem_arbiter_if #(.WORD_SIZE(WS), .ADDR_LEN(AL)) lif ();

   dmem_arbiter #(.WORD_SIZE(WS), .ADDR_LEN(AL), .MEM_SIZE(MS), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rstn(rstn), .p(pif.slave), .l(lif.slave),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr] <= m_wdata;
         else      m_rdata     <= mem[m_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pr, input logic pw, input int pa, input logic [WS-1:0] pd,
                        input logic lr, input logic lw, input int la, input logic [WS-1:0] ld);
      pif.req = pr; pif.we = pw; pif.addr = AL'(pa); pif.wdata = pd;
      lif.req = lr; lif.we = lw; lif.addr = AL'(la); lif.wdata = ld;
   endtask

   task automatic tick();
      resp_t         e;
      logic          egp, egl, we, inr;
      int            a;
      logic [WS-1:0] wd;
      @(negedge clk);
      if (!rstn) begin
         chk("rst_p_gnt", pif.gnt, 0);
         chk("rst_l_gnt", lif.gnt, 0);
         chk("rst_m_en", m_en, 0);
         chk("rst_rvalid", {pif.rvalid, lif.rvalid, pif.err, lif.err}, 0);
         chk("rst_rdata", {pif.rdata, lif.rdata}, 0);
         sbq.delete();
         ms = 0;
         gl_last = 1'b0;
      end else begin
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.owner ? "l_rvalid" : "p_rvalid", e.owner ? lif.rvalid : pif.rvalid, 1);
            chk(e.owner ? "l_rdata" : "p_rdata", e.owner ? lif.rdata : pif.rdata, e.rdata);
            chk(e.owner ? "l_err" : "p_err", e.owner ? lif.err : pif.err, e.err);
            chk("other_resp", e.owner ? {pif.rvalid, pif.rdata} : {lif.rvalid, lif.rdata}, 0);
         end else begin
            chk("idle_rvalid", {pif.rvalid, lif.rvalid}, 0);
         end
         egl = lif.req && (ms == LIM);
         egp = pif.req && !egl;
         egl = lif.req && !egp;
         chk("p_gnt", pif.gnt, egp);
         chk("l_gnt", lif.gnt, egl);
         if (egp || egl) begin
            we  = egl ? lif.we : pif.we;
            a   = egl ? int'(lif.addr) : int'(pif.addr);
            wd  = egl ? lif.wdata : pif.wdata;
            inr = (a < MS);
            chk("m_en", m_en, inr);
            if (inr) begin
               chk("m_addr", m_addr, a);
               chk("m_we", m_we, we);
               if (we) chk("m_wdata", m_wdata, wd);
            end
            e.owner = egl;
            e.err   = !inr;
            e.rdata = (inr && !we) ? ref_mem[a] : '0;
            sbq.push_back(e);
            if (inr && we) ref_mem[a] = wd;
            if (egl) l_accepts++;
         end else begin
            chk("idle_m_en", m_en, 0);
         end
         if (lif.req && !egl) ms = (ms == LIM) ? ms : ms + 1;
         else                 ms = 0;
         gl_last = egl;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int la;
      for (int i = 0; i < 32; i++) begin
         mem[i]     = 32'hA500_0000 | i;
         ref_mem[i] = 32'hA500_0000 | i;
      end
      mem[3] = 32'h11; ref_mem[3] = 32'h11;
      mem[4] = 32'h22; ref_mem[4] = 32'h22;
      m_rdata = '0;

      // reset with both requesting
      rstn = 1'b0;
      drive(1, 0, 0, 0, 1, 0, 1, 0);
      tick();
      tick();
      rstn = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // P write then read back
      drive(1, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
      tick();
      drive(1, 0, 7, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("raw_ref", ref_mem[7], 32'hDEADBEEF);

      // contention: L must be accepted every fifth cycle
      l_accepts = 0;
      la = 1;
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, i % 16, 0, 1, 0, la, 0);
         tick();
         if (gl_last) la = (la + 5) % MS;
      end
      chk("l_accept_count", l_accepts, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // out-of-range read and write from L
      drive(0, 0, 0, 0, 1, 0, 25, 0);
      tick();
      drive(0, 0, 0, 0, 1, 1, 25, 32'h0BAD_0BAD);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("oor_mem_untouched", mem[25], 32'hA500_0019);

      // response routing across back-to-back owners
      drive(0, 0, 0, 0, 1, 0, 3, 0);
      tick();
      drive(1, 0, 4, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // L cancels before grant
      drive(1, 0, 5, 0, 1, 0, 6, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // reset in the cycle after an accepted P read
      drive(1, 0, 9, 0, 1, 0, 2, 0);
      tick();
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      l_accepts = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, (i + 3) % 16, 0, 1, 0, 10, 0);
         tick();
      end
      chk("post_rst_l_accepts", l_accepts, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule
